// File: rtl/neopixel_strip_ctrl.sv
// WS2812-style strip driver: per-pixel GRB colour registers shifted out as
// width-modulated pulses, followed by a low latch interval.
`default_nettype none

module neopixel_strip_ctrl #(
    parameter int NUM_PIXELS = 8,
    parameter int T0H        = 18,
    parameter int T1H        = 35,
    parameter int T_BIT      = 63,
    parameter int T_LATCH    = 2500,
    localparam int PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [PIX_W-1:0] pixel_index_i,
    input  logic [1:0]       color_index_i,
    input  logic [7:0]       color_level_i,
    input  logic             load_color_i,
    input  logic             send_it_i,
    output logic             neo_data_o,
    output logic             ready_to_load_o,
    output logic             ready_to_send_o
);

    localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    if (!(1 <= T0H && T0H < T1H && T1H < T_BIT) || (T_LATCH < 1)) begin : g_param_check
        $error("neopixel_strip_ctrl: need 1 <= T0H < T1H < T_BIT and T_LATCH >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       ch_q, ch_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             neo_data_q, neo_data_d;
    logic [7:0]       color_q [NUM_PIXELS][3];

    logic             load_en;
    logic [7:0]       cur_byte;
    logic             cur_bit;
    logic [CNT_W-1:0] high_len;
    logic             last_bit;

    // Colour registers are frozen while busy, so they double as the frame snapshot.
    assign load_en  = (state_q == S_IDLE) && load_color_i && !send_it_i &&
                      (int'(pixel_index_i) < NUM_PIXELS) && (color_index_i < 2'd3);
    assign cur_byte = color_q[pix_q][ch_q];
    assign cur_bit  = cur_byte[3'd7 - bit_q];
    assign high_len = cur_bit ? CNT_W'(T1H) : CNT_W'(T0H);
    assign last_bit = (bit_q == 3'd7) && (ch_q == 2'd2) && (pix_q == PIX_W'(NUM_PIXELS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            ch_q       <= '0;
            pix_q      <= '0;
            neo_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            neo_data_q <= neo_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    color_q[p][c] <= '0;
                end
            end
        end else if (load_en) begin
            color_q[pixel_index_i][color_index_i] <= color_level_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        case (state_q)
            S_IDLE: begin
                if (send_it_i) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ch_d    = '0;
                    pix_d   = '0;
                end
            end
            S_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == high_len - 1'b1) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == CNT_W'(T_BIT - 1)) begin
                    cnt_d = '0;
                    if (last_bit) begin
                        state_d = S_LATCH;
                        bit_d   = '0;
                        ch_d    = '0;
                        pix_d   = '0;
                    end else begin
                        state_d = S_HIGH;
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
                            if (ch_q == 2'd2) begin
                                ch_d  = '0;
                                pix_d = pix_q + 1'b1;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == CNT_W'(T_LATCH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_to_load_o = (state_q == S_IDLE);
        ready_to_send_o = (state_q == S_IDLE);
        neo_data_d      = (state_d == S_HIGH);
        neo_data_o      = neo_data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_neopixel_strip_ctrl.sv
// Directed bench for neopixel_strip_ctrl with short timing parameters.
`default_nettype none

module tb_neopixel_strip_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pix;
    logic [1:0] col;
    logic [7:0] lvl;
    logic       load;
    logic       send;
    logic       neo, rl, rs;
    logic       neo3, rl3, rs3;

    int tests_run = 0;
    int fails     = 0;
    int widths [72];

    always #5 clk = ~clk;

    neopixel_strip_ctrl #(
        .NUM_PIXELS(2), .T0H(2), .T1H(4), .T_BIT(6), .T_LATCH(10)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pixel_index_i(pix[0]), .color_index_i(col),
        .color_level_i(lvl), .load_color_i(load), .send_it_i(send),
        .neo_data_o(neo), .ready_to_load_o(rl), .ready_to_send_o(rs)
    );

    neopixel_strip_ctrl #(
        .NUM_PIXELS(3), .T0H(2), .T1H(4), .T_BIT(6), .T_LATCH(10)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .pixel_index_i(pix), .color_index_i(col),
        .color_level_i(lvl), .load_color_i(load), .send_it_i(send),
        .neo_data_o(neo3), .ready_to_load_o(rl3), .ready_to_send_o(rs3)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_px(input logic [1:0] p, input logic [1:0] c, input logic [7:0] l);
        @(negedge clk);
        pix  = p;
        col  = c;
        lvl  = l;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Leaves the caller on the first negedge after the acceptance edge.
    task automatic start_send();
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic capture(input bit sel, input int npix);
        int   hi;
        int   shape_bad;
        int   busy_bad;
        logic line, r1, r2;
        shape_bad = 0;
        busy_bad  = 0;
        for (int b = 0; b < npix * 24; b++) begin
            hi = 0;
            for (int k = 0; k < 6; k++) begin
                line = sel ? neo3 : neo;
                r1   = sel ? rl3 : rl;
                r2   = sel ? rs3 : rs;
                if (line === 1'b1) begin
                    if (hi == k) hi++;
                    else shape_bad++;
                end else if (line !== 1'b0) begin
                    shape_bad++;
                end
                if (r1 !== 1'b0 || r2 !== 1'b0) busy_bad++;
                @(negedge clk);
            end
            widths[b] = hi;
        end
        for (int k = 0; k < 10; k++) begin
            line = sel ? neo3 : neo;
            r1   = sel ? rl3 : rl;
            r2   = sel ? rs3 : rs;
            if (line !== 1'b0) shape_bad++;
            if (r1 !== 1'b0 || r2 !== 1'b0) busy_bad++;
            @(negedge clk);
        end
        r1 = sel ? rl3 : rl;
        r2 = sel ? rs3 : rs;
        tests_run++;
        if (shape_bad != 0) begin
            fails++;
            $display("FAIL frame_shape: %0d bad samples, expected 0", shape_bad);
        end
        tests_run++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL busy_span: ready high on %0d busy cycles, expected 0", busy_bad);
        end
        tests_run++;
        if (r1 !== 1'b1 || r2 !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_frame: load=%b send=%b expected 1 1", r1, r2);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        pix   = 2'd0;
        col   = 2'd0;
        lvl   = 8'hFF;
        load  = 1'b1;
        send  = 1'b1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (neo !== 1'b0 || rl !== 1'b1 || rs !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: neo=%b rl=%b rs=%b expected 0 1 1", neo, rl, rs);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (neo !== 1'b0 || rl !== 1'b1 || rs !== 1'b1) begin
            fails++;
            $display("FAIL reset_ignores_send: neo=%b rl=%b rs=%b expected 0 1 1", neo, rl, rs);
        end
        @(negedge clk);
        load  = 1'b0;
        send  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_default_frame();
        do_reset();
        start_send();
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != 2) begin
                fails++;
                $display("FAIL default_width[%0d]: got %0d expected 2", i, widths[i]);
            end
        end
    endtask

    task automatic test_green_a5();
        int exp_a5 [8] = '{4, 2, 4, 2, 2, 4, 2, 4};
        do_reset();
        load_px(2'd0, 2'd0, 8'hA5);
        start_send();
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != ((i < 8) ? exp_a5[i] : 2)) begin
                fails++;
                $display("FAIL a5_width[%0d]: got %0d expected %0d", i, widths[i],
                         (i < 8) ? exp_a5[i] : 2);
            end
        end
    endtask

    task automatic test_order();
        do_reset();
        load_px(2'd1, 2'd2, 8'h01);
        load_px(2'd0, 2'd1, 8'h80);
        start_send();
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != ((i == 8 || i == 47) ? 4 : 2)) begin
                fails++;
                $display("FAIL order_width[%0d]: got %0d expected %0d", i, widths[i],
                         (i == 8 || i == 47) ? 4 : 2);
            end
        end
    endtask

    task automatic test_invalid_load();
        do_reset();
        load_px(2'd0, 2'd3, 8'hFF);
        load_px(2'd1, 2'd3, 8'hFF);
        start_send();
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != 2) begin
                fails++;
                $display("FAIL bad_color_width[%0d]: got %0d expected 2", i, widths[i]);
            end
        end
        do_reset();
        load_px(2'd3, 2'd0, 8'hFF);
        start_send();
        capture(1'b1, 3);
        for (int i = 0; i < 72; i++) begin
            tests_run++;
            if (widths[i] != 2) begin
                fails++;
                $display("FAIL bad_pixel_width[%0d]: got %0d expected 2", i, widths[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        @(negedge clk);
        pix  = 2'd0;
        col  = 2'd0;
        lvl  = 8'hFF;
        load = 1'b1;
        send = 1'b1;
        @(negedge clk);
        load = 1'b0;
        send = 1'b0;
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != 2) begin
                fails++;
                $display("FAIL load_send_same_width[%0d]: got %0d expected 2", i, widths[i]);
            end
        end
        start_send();
        repeat (5) @(negedge clk);
        load_px(2'd0, 2'd0, 8'hFF);
        n = 0;
        while (rl !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (rl !== 1'b1) begin
            fails++;
            $display("FAIL busy_wait_timeout: ready=%b expected 1", rl);
        end
        start_send();
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != 2) begin
                fails++;
                $display("FAIL busy_load_width[%0d]: got %0d expected 2", i, widths[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        load_px(2'd0, 2'd0, 8'hFF);
        start_send();
        repeat (19) @(negedge clk);
        tests_run++;
        if (neo !== 1'b1) begin
            fails++;
            $display("FAIL mid_frame_high: neo=%b expected 1", neo);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (neo !== 1'b0 || rl !== 1'b1 || rs !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_outputs: neo=%b rl=%b rs=%b expected 0 1 1", neo, rl, rs);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (neo !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: %0d high samples, expected 0", bad);
        end
        rst_n = 1'b1;
        start_send();
        capture(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            tests_run++;
            if (widths[i] != 2) begin
                fails++;
                $display("FAIL post_reset_width[%0d]: got %0d expected 2", i, widths[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pix   = 2'd0;
        col   = 2'd0;
        lvl   = 8'h00;
        load  = 1'b0;
        send  = 1'b0;
        test_reset();
        test_default_frame();
        test_green_a5();
        test_order();
        test_invalid_load();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/neopixel_strip_ctrl.md
NEOPIXEL_STRIP_CTRL -- requirements
Module: neopixel_strip_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 8: number of pixels in the strip (>=1); pixel index width PIX_W = max(1, $clog2(NUM_PIXELS)).
REQ-002 Parameter T0H, default 18: clock cycles neo_data is high for a 0 bit.
REQ-003 Parameter T1H, default 35: clock cycles neo_data is high for a 1 bit.
REQ-004 Parameter T_BIT, default 63: total clock cycles per bit period.
REQ-005 Parameter T_LATCH, default 2500: clock cycles neo_data is held low after the last bit.
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 pixel_index  input  PIX_W  pixel addressed by load_color.
REQ-009 color_index  input  2  channel select: 0=green, 1=red, 2=blue, 3=invalid.
REQ-010 color_level  input  8  intensity written by load_color.
REQ-011 load_color  input  1  write request, sampled on rising edge.
REQ-012 send_it  input  1  start-transmission request, sampled on rising edge.
REQ-013 neo_data  output  1  registered serial line to the strip.
REQ-014 ready_to_load  output  1  high when load_color is accepted this cycle.
REQ-015 ready_to_send  output  1  high when send_it is accepted this cycle.

Function
REQ-016 Storage: NUM_PIXELS x 3 x 8-bit color registers.
REQ-017 States: IDLE, SEND_HIGH, SEND_LOW, LATCH; ready_to_load = ready_to_send = (state==IDLE).
REQ-018 IDLE, load_color=1, send_it=0, pixel_index<NUM_PIXELS, color_index<3: register written at that edge.
REQ-019 load_color with color_index=3 or pixel_index>=NUM_PIXELS: ignored, no register change, state unchanged.
REQ-020 load_color outside IDLE: ignored.
REQ-021 IDLE with send_it=1: accepted; load_color on same edge ignored (send has priority); next state SEND_HIGH.
REQ-022 send_it outside IDLE: ignored; no queuing.
REQ-023 Bit order: pixel 0 first, then ascending; per pixel green, red, blue; each byte MSB first; NUM_PIXELS*24 bits total.
REQ-024 Data shifted out is the register content as of the send_it acceptance edge.
REQ-025 Per bit: neo_data high for T0H (bit 0) or T1H (bit 1) cycles, then low for T_BIT minus that, exactly T_BIT cycles per bit, no gaps between bits.
REQ-026 First high cycle of bit 0 is the cycle immediately after the send_it acceptance edge.
REQ-027 After final bit's low phase: LATCH, neo_data low for T_LATCH cycles, then IDLE; ready outputs rise on the following cycle.
REQ-028 Busy span: exactly NUM_PIXELS*24*T_BIT + T_LATCH cycles with ready_to_load = ready_to_send = 0.
REQ-029 Bit, byte and pixel counters wrap only at end of strip; no partial frames.
REQ-030 Elaboration SHALL fail if not (1 <= T0H < T1H < T_BIT) or T_LATCH < 1.

Reset
REQ-031 reset=0 asynchronously forces IDLE, neo_data=0, all color registers 0, all counters 0.
REQ-032 While reset=0: ready_to_load=1, ready_to_send=1; load_color and send_it ignored.
REQ-033 Reset mid-transmission aborts the frame immediately; neo_data low with no further pulses.

Verification (NUM_PIXELS=2, T0H=2, T1H=4, T_BIT=6, T_LATCH=10)
REQ-034 Reset then send_it=1 -> 48 pulses each 2 high/4 low, then 10 low, ready outputs low for 298 cycles then high.
REQ-035 Load pixel 0 green=0xA5, send -> first 8 pulse widths 4,2,4,2,2,4,2,4; remaining 40 pulses width 2.
REQ-036 Load pixel 1 blue=0x01 and pixel 0 red=0x80, send -> pulse 9 width 4 and pulse 48 width 4; all others width 2.
REQ-037 load_color with color_index=3, and with pixel_index=2, then send -> all 48 pulses width 2.
REQ-038 load_color and send_it asserted same IDLE cycle, level 0xFF -> transmission starts, all pulses width 2; load_color during busy -> no change on next frame.
REQ-039 reset=0 at cycle 20 of a frame -> neo_data 0 immediately, both ready outputs 1, next frame all width 2.
